// File: rtl/noc_pkg.sv
// Shared definitions for the NoC node interface: header field layout,
// injector FSM encoding and the header-pack helper.
package noc_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;
  localparam int unsigned NOC_ID_WIDTH   = 4;
  localparam int unsigned LEN_WIDTH      = 8;

  localparam int unsigned DEST_X_LSB = 0;
  localparam int unsigned DEST_Y_LSB = DEST_X_LSB + NOC_ID_WIDTH;
  localparam int unsigned SRC_X_LSB  = DEST_Y_LSB + NOC_ID_WIDTH;
  localparam int unsigned SRC_Y_LSB  = SRC_X_LSB + NOC_ID_WIDTH;
  localparam int unsigned LEN_LSB    = SRC_Y_LSB + NOC_ID_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } inj_state_e;

  // Field offsets scale with id_width so nodes built with a non-default
  // coordinate width still produce a packed, LSB-first header.
  function automatic logic [NOC_DATA_WIDTH-1:0] pack_header(
    input int unsigned               id_width,
    input logic [NOC_DATA_WIDTH-1:0] dest_x,
    input logic [NOC_DATA_WIDTH-1:0] dest_y,
    input logic [NOC_DATA_WIDTH-1:0] src_x,
    input logic [NOC_DATA_WIDTH-1:0] src_y,
    input logic [LEN_WIDTH-1:0]      len
  );
    logic [NOC_DATA_WIDTH-1:0] mask;
    logic [NOC_DATA_WIDTH-1:0] hdr;
    mask = '1;
    mask = ~(mask << id_width);
    hdr  = '0;
    hdr  = hdr | (dest_x & mask);
    hdr  = hdr | ((dest_y & mask) << id_width);
    hdr  = hdr | ((src_x & mask) << (2 * id_width));
    hdr  = hdr | ((src_y & mask) << (3 * id_width));
    hdr  = hdr | (NOC_DATA_WIDTH'(len) << (4 * id_width));
    return hdr;
  endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// Core-side command/payload handshakes and router-side flit handshake of
// the packet injector, bundled as one interface.
interface noc_packet_injector_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_dest_x;
  logic [ID_WIDTH-1:0]   cmd_dest_y;
  logic [7:0]            cmd_len;

  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_in;

  logic                  sender_valid;
  logic                  sender_ready;
  logic [DATA_WIDTH-1:0] sender_flit;
  logic                  sender_is_header;
  logic                  sender_is_tail;

  modport master (
    input  cmd_valid, cmd_dest_x, cmd_dest_y, cmd_len,
    input  data_valid, data_in,
    input  sender_ready,
    output cmd_ready, data_ready,
    output sender_valid, sender_flit, sender_is_header, sender_is_tail
  );

  modport slave (
    output cmd_valid, cmd_dest_x, cmd_dest_y, cmd_len,
    output data_valid, data_in,
    output sender_ready,
    input  cmd_ready, data_ready,
    input  sender_valid, sender_flit, sender_is_header, sender_is_tail
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/count status;
// shared by the injector and the receive-side ejector.
module noc_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           cnt;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (cnt == FULL_COUNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the cleared pointers make any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Builds wormhole packets (header + buffered payload, tail-marked last flit)
// for a router local port and counts completed packets.
module noc_packet_injector
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  noc_packet_injector_if.master bus,
  output logic [7:0]            pkt_sent,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  inj_state_e            state, state_n;
  logic [LEN_WIDTH-1:0]  remaining, remaining_n;
  logic                  out_valid, out_valid_n;
  logic                  out_hdr, out_hdr_n;
  logic                  out_tail, out_tail_n;
  logic [DATA_WIDTH-1:0] out_flit, out_flit_n;
  logic [7:0]            pkt_cnt, pkt_cnt_n;
  logic                  cmd_ready_q, busy_q;

  logic                  fifo_rd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [AW:0]           fifo_count;

  logic                  xfer;
  logic                  load;
  logic [NOC_DATA_WIDTH-1:0] hdr_word;

  noc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (noc_clk),
    .rst_n   (noc_rst_n),
    .wr_en   (bus.data_valid),
    .wr_data (bus.data_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign xfer     = out_valid && bus.sender_ready;
  assign hdr_word = pack_header(ID_WIDTH,
                                NOC_DATA_WIDTH'(bus.cmd_dest_x),
                                NOC_DATA_WIDTH'(bus.cmd_dest_y),
                                NOC_DATA_WIDTH'(X_ID),
                                NOC_DATA_WIDTH'(Y_ID),
                                bus.cmd_len);

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    out_valid_n = out_valid;
    out_flit_n  = out_flit;
    out_hdr_n   = out_hdr;
    out_tail_n  = out_tail;
    pkt_cnt_n   = pkt_cnt;
    fifo_rd     = 1'b0;
    load        = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_ready_q && bus.cmd_valid) begin
          out_valid_n = 1'b1;
          out_flit_n  = DATA_WIDTH'(hdr_word);
          out_hdr_n   = 1'b1;
          out_tail_n  = (bus.cmd_len == '0);
          remaining_n = bus.cmd_len;
          state_n     = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          out_hdr_n   = 1'b0;
          out_valid_n = 1'b0;
          if (out_tail) begin
            out_tail_n = 1'b0;
            pkt_cnt_n  = pkt_cnt + 8'd1;
            state_n    = IDLE;
          end else begin
            state_n = BODY;
            load    = !fifo_empty;
          end
        end
      end
      BODY: begin
        if (xfer && out_tail) begin
          out_valid_n = 1'b0;
          out_tail_n  = 1'b0;
          pkt_cnt_n   = pkt_cnt + 8'd1;
          state_n     = IDLE;
        end else if (!out_valid || xfer) begin
          out_valid_n = 1'b0;
          load        = !fifo_empty;
        end
      end
      default: state_n = IDLE;
    endcase

    // The output register is refilled from the FIFO head in the same cycle
    // the previous flit leaves, so an unstalled packet streams without gaps.
    if (load) begin
      fifo_rd     = 1'b1;
      out_valid_n = 1'b1;
      out_flit_n  = fifo_rd_data;
      out_tail_n  = (remaining == 8'd1);
      remaining_n = remaining - 8'd1;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      out_valid   <= 1'b0;
      out_flit    <= '0;
      out_hdr     <= 1'b0;
      out_tail    <= 1'b0;
      pkt_cnt     <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      remaining   <= remaining_n;
      out_valid   <= out_valid_n;
      out_flit    <= out_flit_n;
      out_hdr     <= out_hdr_n;
      out_tail    <= out_tail_n;
      pkt_cnt     <= pkt_cnt_n;
      cmd_ready_q <= (state_n == IDLE);
      busy_q      <= (state_n != IDLE);
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.data_ready       = !fifo_full;
  assign bus.sender_valid     = out_valid;
  assign bus.sender_flit      = out_flit;
  assign bus.sender_is_header = out_hdr;
  assign bus.sender_is_tail   = out_tail;
  assign pkt_sent             = pkt_cnt;
  assign busy                 = busy_q;

  fifo_status_consistent: assert property (
    @(posedge noc_clk) disable iff (!noc_rst_n) fifo_empty == (fifo_count == '0)
  );

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: inputs driven and outputs sampled
// on the falling clock edge, expected values hand-computed.
module tb_noc_packet_injector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pkt_sent;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  noc_packet_injector_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  noc_packet_injector #(
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .X_ID       (0),
    .Y_ID       (0),
    .FIFO_DEPTH (8)
  ) dut (
    .noc_clk   (clk),
    .noc_rst_n (rst_n),
    .bus       (bus),
    .pkt_sent  (pkt_sent),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic push_words(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.data_valid = 1'b1;
      bus.data_in    = base + i;
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len);
    int unsigned waited = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: got %b expected 1", bus.cmd_ready);
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_dest_x = dx;
    bus.cmd_dest_y = dy;
    bus.cmd_len    = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, busy, bus.cmd_ready,
         bus.data_ready, pkt_sent} !== {6'b000001, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b h=%b t=%b busy=%b cr=%b dr=%b pkt=%0d expected 0 0 0 0 0 1 0",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, busy,
               bus.cmd_ready, bus.data_ready, pkt_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] ef [4] = '{32'h0003_0011, 32'hA0, 32'hA1, 32'hA2};
    bus.sender_ready = 1'b1;
    push_words(32'hA0, 3);
    send_cmd(4'd1, 4'd1, 8'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
          {1'b1, i == 0, i == 3, ef[i]}) begin
        errors++;
        $display("FAIL basic_flit%0d: got v=%b h=%b t=%b flit=%h expected v=1 h=%b t=%b flit=%h",
                 i, bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit,
                 i == 0, i == 3, ef[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.sender_valid, busy, pkt_sent} !== {2'b00, 8'd1}) begin
      errors++;
      $display("FAIL basic_done: got v=%b busy=%b pkt=%0d expected v=0 busy=0 pkt=1",
               bus.sender_valid, busy, pkt_sent);
    end
  endtask

  task automatic test_len0;
    send_cmd(4'd1, 4'd0, 8'd0);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
        {3'b111, 32'h0000_0001}) begin
      errors++;
      $display("FAIL len0_flit: got v=%b h=%b t=%b flit=%h expected v=1 h=1 t=1 flit=00000001",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
    end
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, busy, bus.cmd_ready, pkt_sent} !== {3'b001, 8'd2}) begin
      errors++;
      $display("FAIL len0_done: got v=%b busy=%b cr=%b pkt=%0d expected v=0 busy=0 cr=1 pkt=2",
               bus.sender_valid, busy, bus.cmd_ready, pkt_sent);
    end
  endtask

  task automatic test_backpressure;
    bus.sender_ready = 1'b0;
    push_words(32'hB0, 3);
    send_cmd(4'd2, 4'd3, 8'd3);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
          {3'b110, 32'h0003_0032}) begin
        errors++;
        $display("FAIL bp_hdr_hold%0d: got v=%b h=%b t=%b flit=%h expected v=1 h=1 t=0 flit=00030032",
                 k, bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
      end
      @(negedge clk);
    end
    bus.sender_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
        {3'b100, 32'hB0}) begin
      errors++;
      $display("FAIL bp_b0: got v=%b h=%b t=%b flit=%h expected v=1 h=0 t=0 flit=000000b0",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
    end
    @(negedge clk);
    bus.sender_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
          {3'b100, 32'hB1}) begin
        errors++;
        $display("FAIL bp_b1_hold%0d: got v=%b h=%b t=%b flit=%h expected v=1 h=0 t=0 flit=000000b1",
                 k, bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
      end
      @(negedge clk);
    end
    bus.sender_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
        {3'b101, 32'hB2}) begin
      errors++;
      $display("FAIL bp_b2_tail: got v=%b h=%b t=%b flit=%h expected v=1 h=0 t=1 flit=000000b2",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
    end
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, pkt_sent} !== {1'b0, 8'd3}) begin
      errors++;
      $display("FAIL bp_done: got v=%b pkt=%0d expected v=0 pkt=3", bus.sender_valid, pkt_sent);
    end
  endtask

  task automatic test_fifo_full;
    logic [31:0] exp_flit;
    push_words(32'hC0, 8);
    checks++;
    if (bus.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_data_ready: got %b expected 0", bus.data_ready);
    end
    bus.data_valid = 1'b1;
    bus.data_in    = 32'hDEAD;
    @(negedge clk);
    bus.data_valid = 1'b0;
    send_cmd(4'd0, 4'd0, 8'd8);
    for (int i = 0; i < 9; i++) begin
      exp_flit = (i == 0) ? 32'h0008_0000 : 32'hC0 + 32'(i - 1);
      checks++;
      if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
          {1'b1, i == 0, i == 8, exp_flit}) begin
        errors++;
        $display("FAIL full_flit%0d: got v=%b h=%b t=%b flit=%h expected v=1 h=%b t=%b flit=%h",
                 i, bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit,
                 i == 0, i == 8, exp_flit);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.sender_valid, bus.data_ready, pkt_sent} !== {2'b01, 8'd4}) begin
      errors++;
      $display("FAIL full_done: got v=%b dr=%b pkt=%0d expected v=0 dr=1 pkt=4",
               bus.sender_valid, bus.data_ready, pkt_sent);
    end
  endtask

  task automatic test_starved;
    send_cmd(4'd3, 4'd2, 8'd2);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_flit} !== {2'b11, 32'h0002_0023}) begin
      errors++;
      $display("FAIL starve_hdr: got v=%b h=%b flit=%h expected v=1 h=1 flit=00020023",
               bus.sender_valid, bus.sender_is_header, bus.sender_flit);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.sender_valid, busy} !== 2'b01) begin
        errors++;
        $display("FAIL starve_bubble%0d: got v=%b busy=%b expected v=0 busy=1", k, bus.sender_valid, busy);
      end
    end
    bus.data_valid = 1'b1;
    bus.data_in    = 32'hD0;
    @(negedge clk);
    bus.data_in = 32'hD1;
    checks++;
    if ({bus.sender_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL starve_bubble_wr: got v=%b busy=%b expected v=0 busy=1", bus.sender_valid, busy);
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
    checks++;
    if ({bus.sender_valid, bus.sender_is_tail, busy, bus.sender_flit} !== {3'b101, 32'hD0}) begin
      errors++;
      $display("FAIL starve_d0: got v=%b t=%b busy=%b flit=%h expected v=1 t=0 busy=1 flit=000000d0",
               bus.sender_valid, bus.sender_is_tail, busy, bus.sender_flit);
    end
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, bus.sender_is_tail, busy, bus.sender_flit} !== {3'b111, 32'hD1}) begin
      errors++;
      $display("FAIL starve_d1: got v=%b t=%b busy=%b flit=%h expected v=1 t=1 busy=1 flit=000000d1",
               bus.sender_valid, bus.sender_is_tail, busy, bus.sender_flit);
    end
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, busy, pkt_sent} !== {2'b00, 8'd5}) begin
      errors++;
      $display("FAIL starve_done: got v=%b busy=%b pkt=%0d expected v=0 busy=0 pkt=5",
               bus.sender_valid, busy, pkt_sent);
    end
  endtask

  task automatic test_reset_mid;
    push_words(32'hE0, 3);
    send_cmd(4'd1, 4'd2, 8'd3);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_flit} !== {2'b11, 32'h0003_0021}) begin
      errors++;
      $display("FAIL mid_hdr: got v=%b h=%b flit=%h expected v=1 h=1 flit=00030021",
               bus.sender_valid, bus.sender_is_header, bus.sender_flit);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, bus.sender_flit} !== {1'b1, 32'hE1}) begin
      errors++;
      $display("FAIL mid_e1: got v=%b flit=%h expected v=1 flit=000000e1", bus.sender_valid, bus.sender_flit);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, busy, bus.cmd_ready,
         bus.data_ready, pkt_sent} !== {6'b000001, 8'd0}) begin
      errors++;
      $display("FAIL mid_async_reset: got v=%b h=%b t=%b busy=%b cr=%b dr=%b pkt=%0d expected 0 0 0 0 0 1 0",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, busy,
               bus.cmd_ready, bus.data_ready, pkt_sent);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_words(32'hF0, 1);
    send_cmd(4'd0, 4'd1, 8'd1);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
        {3'b110, 32'h0001_0010}) begin
      errors++;
      $display("FAIL post_hdr: got v=%b h=%b t=%b flit=%h expected v=1 h=1 t=0 flit=00010010",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
    end
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit} !==
        {3'b101, 32'hF0}) begin
      errors++;
      $display("FAIL post_f0: got v=%b h=%b t=%b flit=%h expected v=1 h=0 t=1 flit=000000f0",
               bus.sender_valid, bus.sender_is_header, bus.sender_is_tail, bus.sender_flit);
    end
    @(negedge clk);
    checks++;
    if ({bus.sender_valid, busy, pkt_sent} !== {2'b00, 8'd1}) begin
      errors++;
      $display("FAIL post_done: got v=%b busy=%b pkt=%0d expected v=0 busy=0 pkt=1",
               bus.sender_valid, busy, pkt_sent);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_dest_x   = '0;
    bus.cmd_dest_y   = '0;
    bus.cmd_len      = '0;
    bus.data_valid   = 1'b0;
    bus.data_in      = '0;
    bus.sender_ready = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_fifo_full();
    test_starved();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
